// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between the UART and the ALU: gathers {opcode, A, B}, runs the ALU,
// and returns {result, status}, flagging inter-byte timeouts and bytes dropped while busy.
module uart_alu_sequencer #(
    parameter int ALU_LAT     = 1,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       busy,
    output logic       timeout_err,
    output logic       overrun_err
);

    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYC > 0);

    typedef enum logic [2:0] {
        S_OP, S_A, S_B, S_EXEC, S_TX0, S_W0, S_TX1, S_W1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [7:0]       res_q, res_d;
    logic [7:0]       stat_q, stat_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic             overrun_err_q, overrun_err_d;
    logic             frame_busy;

    // States that cannot accept a byte: anything after B is latched until the reply is out.
    assign frame_busy = (state_q == S_EXEC) || (state_q == S_TX0) || (state_q == S_W0) ||
                        (state_q == S_TX1)  || (state_q == S_W1);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        res_d         = res_q;
        stat_d        = stat_q;
        lat_cnt_d     = lat_cnt_q;
        to_cnt_d      = to_cnt_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = overrun_err_q;

        if (rx_valid && frame_busy) begin
            overrun_err_d = 1'b1;
        end

        case (state_q)
            S_OP: begin
                if (rx_valid) begin
                    op_d     = rx_data[7:5];
                    to_cnt_d = '0;
                    state_d  = S_A;
                end
            end
            S_A, S_B: begin
                if (rx_valid) begin
                    to_cnt_d = '0;
                    if (state_q == S_A) begin
                        // A is staged so the ALU operands keep the previous frame until B lands.
                        a_d     = rx_data;
                        state_d = S_B;
                    end else begin
                        alu_a_d   = a_q;
                        alu_b_d   = rx_data;
                        alu_op_d  = op_q;
                        lat_cnt_d = '0;
                        state_d   = S_EXEC;
                    end
                end else if (TO_EN) begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_err_d = 1'b1;
                        to_cnt_d      = '0;
                        state_d       = S_OP;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (lat_cnt_q == LAT_LAST) begin
                    res_d   = alu_result;
                    stat_d  = {op_q, 1'b0, alu_flags};
                    state_d = S_TX0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_TX0: begin
                if (!tx_busy) begin
                    tx_data_d  = res_q;
                    tx_start_d = 1'b1;
                    state_d    = S_W0;
                end
            end
            S_W0: begin
                if (tx_done) begin
                    state_d = S_TX1;
                end
            end
            S_TX1: begin
                if (!tx_busy) begin
                    tx_data_d  = stat_q;
                    tx_start_d = 1'b1;
                    state_d    = S_W1;
                end
            end
            S_W1: begin
                if (tx_done) begin
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase

        busy_d = (state_d != S_OP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OP;
            op_q          <= '0;
            a_q           <= '0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            res_q         <= '0;
            stat_q        <= '0;
            lat_cnt_q     <= '0;
            to_cnt_q      <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            res_q         <= res_d;
            stat_q        <= stat_d;
            lat_cnt_q     <= lat_cnt_d;
            to_cnt_q      <= to_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a small ADD/SUB ALU and a UART TX stand-in.
module tb_uart_alu_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       busy;
    logic       timeout_err;
    logic       overrun_err;

    logic       tx_busy_m;
    logic       hold_busy;
    int         tx_cnt;
    int         n_busy_start;
    logic [7:0] txq[$];

    int n_vec;
    int n_bad;

    uart_alu_sequencer #(.ALU_LAT(1), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
        .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 000 ADD, 001 SUB (C = borrow), others XOR; flags {C,Z,N,V}
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_op)
            3'b000: begin
                alu_wide   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_wide[7:0];
                alu_flags  = {alu_wide[8], alu_result == 8'h00, alu_result[7],
                              (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7])};
            end
            3'b001: begin
                alu_wide   = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = alu_wide[7:0];
                alu_flags  = {alu_wide[8], alu_result == 8'h00, alu_result[7],
                              (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7])};
            end
            default: begin
                alu_result = alu_a ^ alu_b;
                alu_flags  = {1'b0, alu_result == 8'h00, alu_result[7], 1'b0};
            end
        endcase
    end

    // UART TX stand-in: each byte keeps tx_busy high for 8 cycles, then pulses tx_done.
    assign tx_busy = tx_busy_m | hold_busy;
    initial begin
        tx_busy_m    = 1'b0;
        tx_done      = 1'b0;
        tx_cnt       = 0;
        n_busy_start = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_start) begin
                if (tx_busy) n_busy_start++;
                txq.push_back(tx_data);
                tx_cnt    = 8;
                tx_busy_m = 1'b1;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy_m = 1'b0;
                    tx_done   = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_reply(input string nm, input int n0);
        int cyc;
        cyc = 0;
        while (!((txq.size() >= n0 + 2) && !busy) && cyc < 600) begin
            tick();
            cyc++;
        end
        if (cyc >= 600) chk({nm, "_wait"}, 32'd0, 32'd1);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] opb, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] er, input logic [7:0] es,
                             input bit inject);
        int n0;
        int cyc;
        n0 = txq.size();
        send_byte(opb);
        send_byte(a);
        send_byte(b);
        chk({nm, "_alu_a"}, alu_a, a);
        chk({nm, "_alu_b"}, alu_b, b);
        chk({nm, "_alu_op"}, alu_op, opb[7:5]);
        if (inject) begin
            cyc = 0;
            while (txq.size() < n0 + 1 && cyc < 100) begin
                tick();
                cyc++;
            end
            send_byte(8'h55);
        end
        wait_reply(nm, n0);
        chk({nm, "_nbytes"}, txq.size(), n0 + 2);
        if (txq.size() >= n0 + 2) begin
            chk({nm, "_res"}, txq[n0], er);
            chk({nm, "_stat"}, txq[n0+1], es);
        end
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] opb;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] stat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n0;
        int cyc;
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        hold_busy = 1'b0;

        vecs[0] = '{"add_15_10",  8'h00, 8'h0F, 8'h0A, 8'h19, 8'h00};
        vecs[1] = '{"sub_zero",   8'h20, 8'h0A, 8'h0A, 8'h00, 8'h24};
        vecs[2] = '{"add_carry",  8'h00, 8'hFF, 8'h01, 8'h00, 8'h0C};
        vecs[3] = '{"sub_borrow", 8'h3F, 8'h03, 8'h05, 8'hFE, 8'h2A};
        vecs[4] = '{"add_ovf",    8'h1F, 8'h7F, 8'h01, 8'h80, 8'h03};
        vecs[5] = '{"op7_xor",    8'hE0, 8'h0F, 8'hF0, 8'hFF, 8'hE2};

        repeat (3) tick();
        chk("rst_alu_op", alu_op, 3'd0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_overrun", overrun_err, 1'b0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_frame(vecs[i].nm, vecs[i].opb, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].stat, 1'b0);
        end

        // Inter-byte timeout after opcode and A
        n0 = txq.size();
        send_byte(8'h00);
        send_byte(8'h05);
        cyc = 0;
        while (!timeout_err && cyc < 1100) begin
            tick();
            cyc++;
        end
        chk("to_cycles", cyc, 1000);
        chk("to_busy", busy, 1'b0);
        tick();
        chk("to_pulse_width", timeout_err, 1'b0);
        chk("to_no_tx", txq.size(), n0);
        run_frame("after_to", 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0);

        // Byte arriving while the reply is in flight
        chk("ovr_before", overrun_err, 1'b0);
        run_frame("ovr_frame", 8'h00, 8'h20, 8'h22, 8'h42, 8'h00, 1'b1);
        chk("ovr_set", overrun_err, 1'b1);
        run_frame("ovr_next", 8'h20, 8'h09, 8'h04, 8'h05, 8'h20, 1'b0);
        chk("ovr_sticky", overrun_err, 1'b1);

        // TX backpressure: tx_busy held for 200 cycles once the result is ready
        n0 = txq.size();
        hold_busy = 1'b1;
        send_byte(8'h3F);
        send_byte(8'h03);
        send_byte(8'h05);
        repeat (200) tick();
        chk("bp_no_start", txq.size(), n0);
        hold_busy = 1'b0;
        wait_reply("bp", n0);
        repeat (20) tick();
        chk("bp_nbytes", txq.size(), n0 + 2);
        if (txq.size() >= n0 + 2) begin
            chk("bp_res", txq[n0], 8'hFE);
            chk("bp_stat", txq[n0+1], 8'h2A);
        end
        chk("start_while_busy", n_busy_start, 0);

        // Reset in the middle of a frame
        send_byte(8'h00);
        send_byte(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_alu_op", alu_op, 3'd0);
        chk("mid_rst_alu_a", alu_a, 8'h00);
        chk("mid_rst_alu_b", alu_b, 8'h00);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_tx_start", tx_start, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_timeout", timeout_err, 1'b0);
        chk("mid_rst_overrun", overrun_err, 1'b0);
        run_frame("after_rst", 8'h00, 8'h02, 8'h03, 8'h05, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
